// File: rtl/arith_unit_ctrl.sv
// Request sequencer for the shared shift/add/sub datapath: accept, drive, settle, capture, hand back.
// Define ARITH_CTRL_ERRCNT_EN to add the saturating o_err_count output.
module arith_unit_ctrl #(
  parameter int BITS    = 32,
  parameter int LATENCY = 1,
  parameter int CNT_W   = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [1:0]       i_op,
  input  logic [BITS-1:0]  i_arg_A,
  input  logic [BITS-1:0]  i_arg_B,
  output logic [1:0]       o_dp_op,
  output logic [BITS-1:0]  o_dp_arg_A,
  output logic [BITS-1:0]  o_dp_arg_B,
  input  logic [BITS-1:0]  i_dp_result,
  input  logic             i_dp_error,
  input  logic             i_dp_overflow,
  output logic             o_valid,
  input  logic             i_ack,
  output logic [BITS-1:0]  o_result,
  output logic             o_error,
  output logic             o_overflow,
  output logic             o_busy,
`ifdef ARITH_CTRL_ERRCNT_EN
  output logic [CNT_W-1:0] o_err_count,
`endif
  output logic [CNT_W-1:0] o_op_count
);

  typedef enum logic [1:0] {IDLE, LOAD, EXEC, DONE} state_t;

  localparam logic [1:0]       OP_RESERVED = 2'd3;
  localparam logic [3:0]       SETTLE_INIT = 4'(LATENCY - 1);
  localparam logic [CNT_W-1:0] CNT_MAX     = '1;

  state_t            state_reg, state_next;
  logic [3:0]        settle_reg;
  logic [1:0]        op_reg;
  logic [BITS-1:0]   arg_a_reg, arg_b_reg, result_reg;
  logic              error_reg, overflow_reg;
  logic [CNT_W-1:0]  op_count_reg;
  logic              accept, capture, complete;

  always_comb begin
    state_next = state_reg;
    accept     = 1'b0;
    capture    = 1'b0;
    complete   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (i_valid) begin
          accept     = 1'b1;
          state_next = (i_op == OP_RESERVED) ? DONE : LOAD;
        end
      end
      LOAD: state_next = EXEC;
      EXEC: begin
        if (settle_reg == 4'd0) begin
          capture    = 1'b1;
          state_next = DONE;
        end
      end
      DONE: begin
        if (i_ack) begin
          complete   = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_reg    <= IDLE;
      settle_reg   <= 4'd0;
      op_reg       <= 2'd0;
      arg_a_reg    <= '0;
      arg_b_reg    <= '0;
      result_reg   <= '0;
      error_reg    <= 1'b0;
      overflow_reg <= 1'b0;
      op_count_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        op_reg    <= i_op;
        arg_a_reg <= i_arg_A;
        arg_b_reg <= i_arg_B;
      end
      if (state_reg == LOAD) begin
        settle_reg <= SETTLE_INIT;
      end else if (state_reg == EXEC && settle_reg != 4'd0) begin
        settle_reg <= settle_reg - 4'd1;
      end
      // Reserved opcodes never touch the datapath; their outcome is fixed.
      if (accept && i_op == OP_RESERVED) begin
        result_reg   <= '0;
        error_reg    <= 1'b1;
        overflow_reg <= 1'b0;
      end else if (capture) begin
        result_reg   <= i_dp_result;
        error_reg    <= i_dp_error;
        overflow_reg <= i_dp_overflow;
      end
      if (complete && op_count_reg != CNT_MAX) begin
        op_count_reg <= op_count_reg + CNT_W'(1);
      end
    end
  end

`ifdef ARITH_CTRL_ERRCNT_EN
  logic [CNT_W-1:0] err_count_reg;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      err_count_reg <= '0;
    end else if (complete && (error_reg || overflow_reg) && err_count_reg != CNT_MAX) begin
      err_count_reg <= err_count_reg + CNT_W'(1);
    end
  end

  assign o_err_count = err_count_reg;
`endif

  assign o_ready    = (state_reg == IDLE);
  assign o_valid    = (state_reg == DONE);
  assign o_busy     = (state_reg != IDLE);
  assign o_dp_op    = op_reg;
  assign o_dp_arg_A = arg_a_reg;
  assign o_dp_arg_B = arg_b_reg;
  assign o_result   = result_reg;
  assign o_error    = error_reg;
  assign o_overflow = overflow_reg;
  assign o_op_count = op_count_reg;

endmodule

// File: tb/tb_arith_unit_ctrl.sv
// Bench for arith_unit_ctrl: two instances (LATENCY 1 / 4, narrow and wide counters) with a
// datapath stub, directed cases and random transactions checked against a reference model.
module tb_arith_unit_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [1:0]        valid_s, ack_s;
  logic [1:0][1:0]   op_s;
  logic [1:0][31:0]  a_s, b_s, xor_s;
  logic [1:0]        ready_w, dvalid_w, err_w, ovf_w, busy_w, dperr_w, dpovf_w;
  logic [1:0][1:0]   dpop_w;
  logic [1:0][31:0]  dpa_w, dpb_w, res_w, dpres_w;
  logic [1:0][15:0]  opc_w;
`ifdef ARITH_CTRL_ERRCNT_EN
  logic [1:0][15:0]  errc_w;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  int opc_m[2];
  int errc_m[2];

  // Datapath stub: {error, overflow, result}.
  function automatic logic [33:0] dp_model(logic [1:0] op, logic [31:0] a, logic [31:0] b);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    case (op)
      2'd0:    dp_model = {1'b0, a[31] ^ a[30], a << 1};
      2'd1:    dp_model = {1'b0, s[32], s[31:0]};
      2'd2:    dp_model = {b > a, 1'b0, a - b};
      default: dp_model = 34'h0;
    endcase
  endfunction

  // What a requester should see for a transaction, given the final datapath perturbation.
  function automatic logic [33:0] ref_txn(logic [1:0] op, logic [31:0] a, logic [31:0] b, logic [31:0] xr);
    logic [33:0] m;
    if (op == 2'd3) begin
      ref_txn = {1'b1, 1'b0, 32'h0};
    end else begin
      m = dp_model(op, a, b);
      ref_txn = {m[33:32], m[31:0] ^ xr};
    end
  endfunction

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
      localparam int LAT = (gi == 0) ? 1 : 4;
      localparam int CW  = (gi == 0) ? 3 : 16;
      logic [CW-1:0] opc_l;
      logic [31:0]   raw_l;
`ifdef ARITH_CTRL_ERRCNT_EN
      logic [CW-1:0] errc_l;
      assign errc_w[gi] = 16'(errc_l);
`endif
      assign {dperr_w[gi], dpovf_w[gi], raw_l} = dp_model(dpop_w[gi], dpa_w[gi], dpb_w[gi]);
      assign dpres_w[gi] = raw_l ^ xor_s[gi];
      assign opc_w[gi]   = 16'(opc_l);

      arith_unit_ctrl #(.BITS(32), .LATENCY(LAT), .CNT_W(CW)) u_dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_valid       (valid_s[gi]),
        .o_ready       (ready_w[gi]),
        .i_op          (op_s[gi]),
        .i_arg_A       (a_s[gi]),
        .i_arg_B       (b_s[gi]),
        .o_dp_op       (dpop_w[gi]),
        .o_dp_arg_A    (dpa_w[gi]),
        .o_dp_arg_B    (dpb_w[gi]),
        .i_dp_result   (dpres_w[gi]),
        .i_dp_error    (dperr_w[gi]),
        .i_dp_overflow (dpovf_w[gi]),
        .o_valid       (dvalid_w[gi]),
        .i_ack         (ack_s[gi]),
        .o_result      (res_w[gi]),
        .o_error       (err_w[gi]),
        .o_overflow    (ovf_w[gi]),
        .o_busy        (busy_w[gi]),
`ifdef ARITH_CTRL_ERRCNT_EN
        .o_err_count   (errc_l),
`endif
        .o_op_count    (opc_l)
      );
    end
  endgenerate

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // One full transaction on instance d; hold = cycles of withheld ack with a rogue request.
  task automatic do_op(int d, logic [1:0] op, logic [31:0] a, logic [31:0] b, int hold,
                       logic [31:0] x2, logic [31:0] x4);
    int lat, k, cmax;
    logic [31:0] xr;
    logic [33:0] e;
    lat  = (d == 0) ? 1 : 4;
    cmax = (d == 0) ? 7 : 65535;
    @(negedge clk);
    chk("ready_idle", 64'(ready_w[d]), 64'(1));
    valid_s[d] = 1'b1; op_s[d] = op; a_s[d] = a; b_s[d] = b;
    @(posedge clk);
    #1;
    valid_s[d] = 1'b0; op_s[d] = 2'($urandom_range(0, 3)); a_s[d] = $urandom; b_s[d] = $urandom;
    k = 0; xr = 32'h0;
    while (k < 40) begin
      @(negedge clk);
      if (dvalid_w[d]) break;
      k++;
      ack_s[d] = (k == 1);
      if (k == 3) begin xor_s[d] = x2; xr = x2; end
      if (k == 5) begin xor_s[d] = x4; xr = x4; end
    end
    ack_s[d] = 1'b0;
    chk("latency", 64'(k), 64'((op == 2'd3) ? 0 : lat + 1));
    e = ref_txn(op, a, b, xr);
    chk("result",   64'(res_w[d]), 64'(e[31:0]));
    chk("error",    64'(err_w[d]), 64'(e[33]));
    chk("overflow", 64'(ovf_w[d]), 64'(e[32]));
    chk("dp_op",    64'(dpop_w[d]), 64'(op));
    chk("dp_arg_a", 64'(dpa_w[d]), 64'(a));
    chk("dp_arg_b", 64'(dpb_w[d]), 64'(b));
    chk("busy_done",  64'(busy_w[d]), 64'(1));
    chk("ready_done", 64'(ready_w[d]), 64'(0));
    for (int i = 0; i < hold; i++) begin
      valid_s[d] = 1'b1; op_s[d] = 2'd1; a_s[d] = 32'hFFFF_FFFF;
      @(negedge clk);
      chk("hold_result", 64'(res_w[d]), 64'(e[31:0]));
    end
    valid_s[d] = 1'b0;
    if (hold > 0) begin
      chk("hold_dp_arg_a", 64'(dpa_w[d]), 64'(a));
      chk("hold_valid",    64'(dvalid_w[d]), 64'(1));
      chk("hold_ready",    64'(ready_w[d]), 64'(0));
    end
    ack_s[d] = 1'b1;
    @(posedge clk);
    #1;
    ack_s[d] = 1'b0;
    xor_s[d] = 32'h0;
    if (opc_m[d] < cmax) opc_m[d]++;
    if ((e[33] || e[32]) && errc_m[d] < cmax) errc_m[d]++;
    @(negedge clk);
    chk("valid_after_ack", 64'(dvalid_w[d]), 64'(0));
    chk("ready_after_ack", 64'(ready_w[d]), 64'(1));
    chk("busy_after_ack",  64'(busy_w[d]), 64'(0));
    chk("op_count",        64'(opc_w[d]), 64'(opc_m[d]));
`ifdef ARITH_CTRL_ERRCNT_EN
    chk("err_count",       64'(errc_w[d]), 64'(errc_m[d]));
`endif
    $display("txn dut=%0d op=%0d A=%08h B=%08h -> result=%08h err=%0d ovf=%0d lat=%0d count=%0d",
             d, op, a, b, res_w[d], err_w[d], ovf_w[d], k, opc_w[d]);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    valid_s = '0; ack_s = '0; op_s = '0; a_s = '0; b_s = '0; xor_s = '0;
    for (int d = 0; d < 2; d++) begin opc_m[d] = 0; errc_m[d] = 0; end
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int d = 0; d < 2; d++) begin
      chk("rst_ready",    64'(ready_w[d]), 64'(1));
      chk("rst_valid",    64'(dvalid_w[d]), 64'(0));
      chk("rst_busy",     64'(busy_w[d]), 64'(0));
      chk("rst_result",   64'(res_w[d]), 64'(0));
      chk("rst_flags",    64'({err_w[d], ovf_w[d]}), 64'(0));
      chk("rst_dp_arg_a", 64'(dpa_w[d]), 64'(0));
      chk("rst_op_count", 64'(opc_w[d]), 64'(0));
    end

    // Reset while instance 1 sits in EXEC.
    @(negedge clk);
    valid_s[1] = 1'b1; op_s[1] = 2'd1; a_s[1] = 32'h7; b_s[1] = 32'h9;
    @(posedge clk);
    #1 valid_s[1] = 1'b0;
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("midrst_busy",     64'(busy_w[1]), 64'(0));
    chk("midrst_ready",    64'(ready_w[1]), 64'(1));
    chk("midrst_valid",    64'(dvalid_w[1]), 64'(0));
    chk("midrst_dp_arg_a", 64'(dpa_w[1]), 64'(0));
    chk("midrst_op_count", 64'(opc_w[1]), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    do_op(1, 2'd1, 32'h0000_0011, 32'h0000_0022, 0, 32'h0, 32'h0);

    // Directed cases on the LATENCY=1 instance.
    do_op(0, 2'd1, 32'h0000_0005, 32'h0000_0003, 0, 32'h0, 32'h0);
    do_op(0, 2'd1, 32'h0000_0001, 32'h0000_0002, 10, 32'h0, 32'h0);
    do_op(0, 2'd3, $urandom, $urandom, 1, 32'h0, 32'h0);
    do_op(0, 2'd0, 32'h4000_0000, 32'h0, 0, 32'h0, 32'h0);

    // LATENCY=4: stub result changes mid-EXEC; only the last value must be captured.
    do_op(1, 2'd1, 32'd100, 32'd23, 0, 32'h0000_00F0, 32'h0000_0F00);
    do_op(1, 2'd3, 32'h1234_5678, 32'h9ABC_DEF0, 2, 32'h0, 32'h0);

    // Random traffic; instance 0's 3-bit counters saturate along the way.
    for (int n = 0; n < 25; n++) begin
      do_op(0, 2'($urandom_range(0, 3)), $urandom, $urandom, int'($urandom_range(0, 3)), 32'h0, 32'h0);
      do_op(1, 2'($urandom_range(0, 3)), $urandom, $urandom, int'($urandom_range(0, 3)), $urandom, $urandom);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
